// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types and arbiter constants.
//   cbus_req_t   : request beat (valid, is_write, size, addr, strobe, data, len)
//   cbus_resp_t  : response beat (ready, last, data)
//   ARB_FIXED/ARB_RR : arbitration policy selectors
//   arb_state_e  : arbiter ownership state
//   id_width()   : grant index width for a channel count, floored at 1
package cbus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational wrap-around priority picker.
//   valid : request vector, one bit per channel
//   base  : channel index that has highest priority this cycle
//   found : at least one valid bit is set
//   index : first set bit at or after base, wrapping modulo NUM_CH
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 1
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [ID_W-1:0]   base,
  output logic              found,
  output logic [ID_W-1:0]   index
);

  logic [NUM_CH-1:0] rotated;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] b, input int k);
    int s;
    s = int'(b) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return ID_W'(s);
  endfunction

  always_comb begin
    // Rotate so that bit 0 of 'rotated' is channel 'base'; the doubled
    // vector supplies the wrapped-around upper channels.
    rotated = NUM_CH'({valid, valid} >> base);
    found   = 1'b0;
    index   = '0;
    // Scan downward so the lowest rotated position is written last and wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found = 1'b1;
        index = wrap_add(base, k);
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// N-input CBus arbiter with burst locking.
//   clk, resetn : clock and synchronous active-low reset
//   ireqs       : per-channel requests from the bus converters
//   iresps      : per-channel responses; only the owner sees traffic
//   oreq        : request forwarded from the owning channel
//   oresp       : response from memory / interconnect
//   busy        : a channel currently owns the bus
//   grant_id    : owning channel index, held while idle
// Ownership is taken in IDLE (one cycle after valid) and released on the
// ready&last beat, which always leaves one idle cycle between grants.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = ARB_RR,
  parameter int ID_W     = id_width(NUM_CH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NUM_CH],
  output cbus_resp_t       iresps [NUM_CH],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [ID_W-1:0]  grant_id
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [0:0]        state;
  logic [ID_W-1:0]   rr_base;
  logic [NUM_CH-1:0] req_valid;
  logic [ID_W-1:0]   pick_base;
  logic [ID_W-1:0]   pick_index;
  logic              pick_found;
  logic              final_beat;

  function automatic logic [ID_W-1:0] next_base(input logic [ID_W-1:0] id);
    if (int'(id) >= NUM_CH - 1) return '0;
    return id + ID_W'(1);
  endfunction

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  // Fixed priority is the picker with its base pinned to channel 0.
  assign pick_base = (ARB_MODE == ARB_RR) ? rr_base : '0;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_picker (
    .valid (req_valid),
    .base  (pick_base),
    .found (pick_found),
    .index (pick_index)
  );

  assign busy       = (state == ST_BUSY);
  assign final_beat = oresp.ready && oresp.last;

  // Owner's request and response pass through combinationally so per-beat
  // write data/strobe track the requester; everyone else sees zeros.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      iresps[i] = '0;
      if (busy && (ID_W'(i) == grant_id)) begin
        oreq      = ireqs[i];
        iresps[i] = oresp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      rr_base  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_index;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The owner keeps the bus even if it drops valid; only the
          // downstream final beat ends the transaction.
          if (final_beat) begin
            state <= ST_IDLE;
            if (ARB_MODE == ARB_RR) rr_base <= next_base(grant_id);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
